// File: rtl/mcash_sb_pkg.sv
// Shared scoreboard types: first-error codes and the shadow record layout.
// Record widths here match the default scoreboard parameters.
package mcash_sb_pkg;

  localparam int SB_OP_W   = 2;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 128;

  typedef enum logic [2:0] {
    SB_OK    = 3'd0,
    SB_OP    = 3'd1,
    SB_ADDR  = 3'd2,
    SB_DATA  = 3'd3,
    SB_UNDER = 3'd4,
    SB_OVER  = 3'd5
  } sb_err_e;

  typedef struct packed {
    logic [SB_OP_W-1:0]   op;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_rec_t;

endpackage

// File: rtl/mcash_sb_fifo.sv
// Single-push/single-pop shadow FIFO; head is combinational, push/pop take effect at the edge.
// No internal backpressure: the caller gates pushes on full (unless popping) and pops on empty.
module mcash_sb_fifo
  import mcash_sb_pkg::*;
#(
  parameter type rec_t = sb_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  rec_t i_dat,
  output rec_t o_head,
  output logic o_full,
  output logic o_empty,
  output logic o_empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  rec_t           r_mem [DEPTH];
  logic [AW:0]    r_wp;
  logic [AW:0]    r_rp;
  logic [AW:0]    w_wp_nxt;
  logic [AW:0]    w_rp_nxt;

  assign w_wp_nxt    = r_wp + {{AW{1'b0}}, i_push};
  assign w_rp_nxt    = r_rp + {{AW{1'b0}}, i_pop};
  assign o_empty     = (r_wp == r_rp);
  // Wrap bit differs with equal index: the writer has lapped the reader.
  assign o_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty_nxt = (w_wp_nxt == w_rp_nxt);
  assign o_head      = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= w_wp_nxt;
      r_rp <= w_rp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/mcash_xbar_scoreboard.sv
// In-order xbar scoreboard: shadow FIFO per (channel, bank), issues checked against the head; results 1 cycle after fire.
// Purely observational: never stalls the xbar; overflowing pushes are dropped and flagged.
module mcash_xbar_scoreboard
  import mcash_sb_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int NUM_BANK = 4,
  parameter  int DEPTH    = 8,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 128,
  parameter  int OP_W     = 2,
  parameter  int LINE_LSB = 4,
  parameter  int CNT_W    = 32,
  localparam int CW       = $clog2(NUM_CH),
  localparam int BW       = $clog2(NUM_BANK)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req_valid_i,
  input  logic [NUM_CH-1:0]          ch_req_allowIn_i,
  input  logic [NUM_CH*OP_W-1:0]     ch_req_op_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_req_data_i,
  input  logic [NUM_BANK-1:0]        bank_htu_valid_i,
  input  logic [NUM_BANK-1:0]        bank_htu_allowIn_i,
  input  logic [NUM_BANK*CW-1:0]     bank_htu_ch_id_i,
  input  logic [NUM_BANK*OP_W-1:0]   bank_htu_opcode_i,
  input  logic [NUM_BANK*ADDR_W-1:0] bank_htu_addr_i,
  input  logic [NUM_BANK*DATA_W-1:0] bank_htu_data_i,
  input  logic                       clr_i,
  output logic                       err_o,
  output logic [2:0]                 err_code_o,
  output logic [CW-1:0]              err_ch_o,
  output logic [BW-1:0]              err_bank_o,
  output logic [CNT_W-1:0]           match_cnt_o,
  output logic [CNT_W-1:0]           mismatch_cnt_o,
  output logic                       idle_o
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  localparam int NQ = NUM_CH * NUM_BANK;
  localparam int NW = $clog2(NUM_CH + NUM_BANK + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_LSB){1'b1}}, {LINE_LSB{1'b0}}};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NW-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [NUM_CH-1:0]   w_push_fire;
  logic [BW-1:0]       w_push_bank [NUM_CH];
  rec_t                w_push_rec  [NUM_CH];
  logic [NUM_CH-1:0]   w_ch_ovf;
  logic [NUM_BANK-1:0] w_pop_fire;
  logic [CW-1:0]       w_pop_ch    [NUM_BANK];
  rec_t                w_bank_head [NUM_BANK];
  logic [NUM_BANK-1:0] w_bank_empty;
  logic [NQ-1:0]       w_full, w_empty, w_empty_nxt, w_push, w_pop, w_ovf;
  rec_t                w_head [NQ];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_push_fire[c] = ch_req_valid_i[c] & ch_req_allowIn_i[c];
    assign w_push_bank[c] = ch_req_addr_i[c*ADDR_W+LINE_LSB +: BW];
    assign w_push_rec[c]  = {ch_req_op_i[c*OP_W +: OP_W],
                             ch_req_addr_i[c*ADDR_W +: ADDR_W] & LINE_MASK,
                             ch_req_data_i[c*DATA_W +: DATA_W]};
    assign w_ch_ovf[c]    = |w_ovf[c*NUM_BANK +: NUM_BANK];
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign w_pop_fire[b]   = bank_htu_valid_i[b] & bank_htu_allowIn_i[b];
    assign w_pop_ch[b]     = bank_htu_ch_id_i[b*CW +: CW];
    assign w_bank_head[b]  = w_head[int'(w_pop_ch[b])*NUM_BANK + b];
    assign w_bank_empty[b] = w_empty[int'(w_pop_ch[b])*NUM_BANK + b];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_qc
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_qb
      localparam int Q = c*NUM_BANK + b;
      logic w_push_req, w_pop_req;
      assign w_push_req = w_push_fire[c] && (w_push_bank[c] == BW'(b));
      assign w_pop_req  = w_pop_fire[b] && (w_pop_ch[b] == CW'(c));
      // A pop frees the slot this edge, so a full FIFO may still accept; empty never bypasses.
      assign w_pop[Q]   = w_pop_req && !w_empty[Q];
      assign w_push[Q]  = w_push_req && (!w_full[Q] || w_pop[Q]);
      assign w_ovf[Q]   = w_push_req && w_full[Q] && !w_pop[Q];

      mcash_sb_fifo #(.rec_t(rec_t), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push[Q]),
        .i_pop      (w_pop[Q]),
        .i_dat      (w_push_rec[c]),
        .o_head     (w_head[Q]),
        .o_full     (w_full[Q]),
        .o_empty    (w_empty[Q]),
        .o_empty_nxt(w_empty_nxt[Q])
      );
    end
  end

  sb_err_e             w_bank_err [NUM_BANK];
  logic [NUM_BANK-1:0] w_match;

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      w_bank_err[b] = SB_OK;
      w_match[b]    = 1'b0;
      if (w_pop_fire[b]) begin
        if (w_bank_empty[b])
          w_bank_err[b] = SB_UNDER;
        else if (w_bank_head[b].op != bank_htu_opcode_i[b*OP_W +: OP_W])
          w_bank_err[b] = SB_OP;
        else if (w_bank_head[b].addr != (bank_htu_addr_i[b*ADDR_W +: ADDR_W] & LINE_MASK))
          w_bank_err[b] = SB_ADDR;
        else if (w_bank_head[b].data != bank_htu_data_i[b*DATA_W +: DATA_W])
          w_bank_err[b] = SB_DATA;
        else
          w_match[b] = 1'b1;
      end
    end
  end

  logic          w_err_any;
  sb_err_e       w_err_code;
  logic [CW-1:0] w_err_ch;
  logic [BW-1:0] w_err_bank;
  logic [NW-1:0] w_err_n;
  logic [NW-1:0] w_match_n;

  // First error wins by lowest bank, then overflow on lowest channel.
  always_comb begin
    w_err_any  = 1'b0;
    w_err_code = SB_OK;
    w_err_ch   = '0;
    w_err_bank = '0;
    w_err_n    = '0;
    w_match_n  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (w_match[b]) w_match_n = w_match_n + NW'(1);
      if (w_bank_err[b] != SB_OK) begin
        w_err_n = w_err_n + NW'(1);
        if (!w_err_any) begin
          w_err_code = w_bank_err[b];
          w_err_ch   = w_pop_ch[b];
          w_err_bank = BW'(b);
        end
        w_err_any = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_ovf[c]) begin
        w_err_n = w_err_n + NW'(1);
        if (!w_err_any) begin
          w_err_code = SB_OVER;
          w_err_ch   = CW'(c);
          w_err_bank = w_push_bank[c];
        end
        w_err_any = 1'b1;
      end
    end
  end

  logic             r_err;
  sb_err_e          r_err_code;
  logic [CW-1:0]    r_err_ch;
  logic [BW-1:0]    r_err_bank;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             r_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_err_code  <= SB_OK;
      r_err_ch    <= '0;
      r_err_bank  <= '0;
      r_match_cnt <= '0;
      r_mis_cnt   <= '0;
      r_idle      <= 1'b1;
    end else begin
      r_idle <= &w_empty_nxt;
      if (clr_i) begin
        r_err       <= 1'b0;
        r_err_code  <= SB_OK;
        r_err_ch    <= '0;
        r_err_bank  <= '0;
        r_match_cnt <= '0;
        r_mis_cnt   <= '0;
      end else begin
        if (w_err_any && !r_err) begin
          r_err      <= 1'b1;
          r_err_code <= w_err_code;
          r_err_ch   <= w_err_ch;
          r_err_bank <= w_err_bank;
        end
        r_match_cnt <= sat_add(r_match_cnt, w_match_n);
        r_mis_cnt   <= sat_add(r_mis_cnt, w_err_n);
      end
    end
  end

  assign err_o          = r_err;
  assign err_code_o     = r_err_code;
  assign err_ch_o       = r_err_ch;
  assign err_bank_o     = r_err_bank;
  assign match_cnt_o    = r_match_cnt;
  assign mismatch_cnt_o = r_mis_cnt;
  assign idle_o         = r_idle;

endmodule

// File: doc/mcash_xbar_scoreboard.md
Name: mcash_xbar_scoreboard

Overview:
Synthesizable in-order scoreboard for the cross-bar. It snoops every accepted channel request and queues the expected record in a shadow FIFO per (channel, bank) pair. It checks every xbar-to-bank HTU issue against the head of the matching FIFO. It sits beside the cross-bar top in the mcash testbench, is parametrised in channel count, bank count, depth and widths, and replaces the per-transaction DPI calls with on-chip error capture and counters.

Parameters:
NUM_CH, 4, number of request channels
NUM_BANK, 4, number of cache banks (power of 2)
DEPTH, 8, shadow entries per (channel, bank) FIFO (power of 2)
ADDR_W, 32, address width
DATA_W, 128, data width
OP_W, 2, compared opcode width
LINE_LSB, 4, address bits below this are masked (line granularity)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_req_valid_i  in  NUM_CH  per-channel request valid
ch_req_allowIn_i  in  NUM_CH  per-channel cross-bar accept
ch_req_op_i  in  NUM_CH*OP_W  per-channel opcode
ch_req_addr_i  in  NUM_CH*ADDR_W  per-channel address
ch_req_data_i  in  NUM_CH*DATA_W  per-channel data
bank_htu_valid_i  in  NUM_BANK  xbar-to-bank valid
bank_htu_allowIn_i  in  NUM_BANK  bank accept
bank_htu_ch_id_i  in  NUM_BANK*$clog2(NUM_CH)  source channel of issue
bank_htu_opcode_i  in  NUM_BANK*OP_W  issued opcode
bank_htu_addr_i  in  NUM_BANK*ADDR_W  issued address
bank_htu_data_i  in  NUM_BANK*DATA_W  issued data
clr_i  in  1  synchronous clear of error capture and counters (FIFOs untouched)
err_o  out  1  sticky error flag
err_code_o  out  3  first error: 0 none, 1 op, 2 addr, 3 data, 4 underflow, 5 overflow
err_ch_o  out  $clog2(NUM_CH)  channel of first error
err_bank_o  out  $clog2(NUM_BANK)  bank of first error
match_cnt_o  out  CNT_W  checked issues that matched
mismatch_cnt_o  out  CNT_W  total errors of all kinds
idle_o  out  1  all shadow FIFOs empty

Behaviour:
- Reset: all pointers and counts 0. err_o=0, err_code_o=0, err_ch_o=0, err_bank_o=0, both counters 0, idle_o=1.
- Push: ch c fires on valid&allowIn in a cycle. Target bank b = addr[LINE_LSB +: log2(NUM_BANK)]. Record {op, addr with bits [LINE_LSB-1:0] zeroed, data} is written to FIFO[c][b] at the clock edge.
- Pop/check: bank b fires on valid&allowIn. The block reads the head of FIFO[ch_id][b] combinationally, compares it in the same cycle, and pops it at the edge. Result registers update 1 cycle after the fire.
- Compare priority: op, then addr (masked), then data. Only the first failing field is coded. An error increments mismatch_cnt_o by 1 per bank per cycle.
- Underflow: fire to an empty FIFO gives code 4. No pop occurs and pointers stay unchanged.
- Overflow: push to a full FIFO gives code 5. The record is dropped and the FIFO is unchanged.
- Simultaneous push and pop on the same FIFO is legal. A FIFO can only see one push (its channel) and one pop (its bank) per cycle. On a full FIFO with a simultaneous pop, the push is accepted (not an overflow). On an empty FIFO with a simultaneous push, the pop is an underflow (no bypass).
- Several errors in one cycle: capture priority is lowest bank index first, then overflow on lowest channel. mismatch_cnt_o adds the popcount of all errors that cycle.
- Error capture: err_code/ch/bank are written only while err_o=0. err_o then holds until clr_i or reset.
- match_cnt_o adds the popcount of matching issues per cycle.
- Counters saturate at all-ones, with no wrap.
- clr_i in the same cycle as a new error: the clear wins, and the error is neither captured nor counted.
- Pointers are log2(DEPTH)+1 bits, and full/empty is decided by the MSB compare.
- idle_o is registered and is the AND of all FIFO empties after the edge.
- Reset asserted mid-traffic discards all shadow contents immediately (asynchronous).

Decomposition:
- Package mcash_sb_pkg holds the err_code enum (SB_OK, SB_OP, SB_ADDR, SB_DATA, SB_UNDER, SB_OVER) and the sb_rec_t struct {op, addr, data}.
- One sub-module, mcash_sb_fifo: single-push/single-pop FIFO of sb_rec_t with full, empty and head outputs. It is instantiated NUM_CH*NUM_BANK times via generate.

Test Plan:
- Ch0 push op=1, addr=0x0000_1008, data=0xA5…; bank0 issue ch_id=0, op=1, addr=0x0000_1000, same data -> match_cnt_o=1, err_o=0, idle_o=1.
- Ch2 push addr 0x20 (bank2); bank2 issue ch_id=2 with data bit0 flipped -> one cycle later err_o=1, err_code_o=3, err_ch_o=2, err_bank_o=2, mismatch_cnt_o=1.
- Bank1 issue ch_id=3 with no prior push -> err_code_o=4, FIFO[3][1] still empty, idle_o stays 1.
- Nine pushes ch1 to bank3 with DEPTH=8, no issues -> 9th push gives err_code_o=5; draining 8 issues in order all match.
- FIFO[0][0] full, ch0 push and bank0 pop in the same cycle -> no overflow, occupancy stays 8, next head is the second record.
- Assert rst_n low mid-traffic with 3 entries queued, then release -> idle_o=1, counters 0, and a subsequent issue reports underflow.
